// File: rtl/audio_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package : audio_pkg                                                   |
// | Brief   : Shared audio-path constants and capture/playback state type |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
package audio_pkg;

  localparam int c_DEPTH    = 16384;
  localparam int c_ADDR_W   = 14;
  localparam int c_SAMPLE_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } audio_state_t;

endpackage
`default_nettype wire

// File: rtl/mic_capture_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Interface : mic_capture_if                                            |
// | Brief     : Audio-controller input FIFO plus capture RAM write port   |
// | Rev       : 1.0  initial release                                      |
// +-----------------------------------------------------------------------+
interface mic_capture_if
  import audio_pkg::*;
#(
  parameter int ADDR_W   = c_ADDR_W,
  parameter int SAMPLE_W = c_SAMPLE_W
) ();

  logic                audio_in_available;
  logic [31:0]         left_channel_audio_in;
  logic                read_audio_in;
  logic [ADDR_W-1:0]   mem_address;
  logic [SAMPLE_W-1:0] mem_data;
  logic                mem_wren;

  modport master (
    input  audio_in_available, left_channel_audio_in,
    output read_audio_in, mem_address, mem_data, mem_wren
  );

  modport slave (
    output audio_in_available, left_channel_audio_in,
    input  read_audio_in, mem_address, mem_data, mem_wren
  );

endinterface
`default_nettype wire

// File: rtl/mic_capture_sample_conditioner.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : sample_conditioner                                           |
// | Brief  : Sample truncation, decimation phase and saturating magnitude |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module sample_conditioner
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = c_SAMPLE_W,
  parameter int DECIM    = 1
) (
  input  wire logic                CLOCK_50,
  input  wire logic                resetn,
  input  wire logic                clear,
  input  wire logic                advance,
  input  wire logic [31:0]         word,
  output logic                     keep,
  output logic [SAMPLE_W-1:0]      sample,
  output logic [SAMPLE_W-2:0]      magnitude
);

  localparam logic [3:0] c_LAST = 4'(DECIM - 1);

  logic [3:0]          r_decim_cnt;
  logic [SAMPLE_W-1:0] w_neg;
  logic                w_is_min;
  logic                w_unused_bits;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_decim_cnt <= '0;
    end else if (clear) begin
      r_decim_cnt <= '0;
    end else if (advance) begin
      r_decim_cnt <= (r_decim_cnt == c_LAST) ? 4'd0 : r_decim_cnt + 4'd1;
    end
  end

  assign keep   = (r_decim_cnt == 4'd0);
  assign sample = word[31 -: SAMPLE_W];

  // The most negative code has no positive twin, so it clips to full scale.
  assign w_neg     = -sample;
  assign w_is_min  = sample[SAMPLE_W-1] & ~(|sample[SAMPLE_W-2:0]);
  assign magnitude = !sample[SAMPLE_W-1] ? sample[SAMPLE_W-2:0] :
                     w_is_min            ? '1                   :
                                           w_neg[SAMPLE_W-2:0];

  assign w_unused_bits = &{1'b0, word[31-SAMPLE_W:0]};

endmodule
`default_nettype wire

// File: rtl/mic_capture.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : mic_capture                                                  |
// | Brief  : Captures decimated microphone samples into a RAM buffer      |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module mic_capture
  import audio_pkg::*;
#(
  parameter int DEPTH    = c_DEPTH,
  parameter int ADDR_W   = c_ADDR_W,
  parameter int SAMPLE_W = c_SAMPLE_W,
  parameter int DECIM    = 1
) (
  input  wire logic             CLOCK_50,
  input  wire logic             resetn,
  input  wire logic             start,
  input  wire logic             stop,
  mic_capture_if.master         bus,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W:0]       sample_count,
  output logic [SAMPLE_W-2:0]   peak
);

  localparam logic [ADDR_W:0] c_LAST_CNT = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] c_ONE      = (ADDR_W+1)'(1);

  audio_state_t        r_state;
  audio_state_t        w_state_nxt;
  logic                r_busy;
  logic                r_done;
  logic                r_mem_wren;
  logic [ADDR_W-1:0]   r_mem_address;
  logic [SAMPLE_W-1:0] r_mem_data;
  logic [ADDR_W:0]     r_sample_count;
  logic [SAMPLE_W-2:0] r_peak;

  logic                w_pop;
  logic                w_start_ok;
  logic                w_capture;
  logic                w_keep;
  logic                w_kept;
  logic                w_last;
  logic [SAMPLE_W-1:0] w_sample;
  logic [SAMPLE_W-2:0] w_mag;

  // The FIFO is drained unconditionally, even while held in reset.
  assign bus.read_audio_in = bus.audio_in_available;
  assign w_pop             = bus.audio_in_available;

  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_capture  = (r_state == ST_CAPTURE);
  assign w_kept     = w_capture && w_pop && w_keep;
  assign w_last     = w_kept && (r_sample_count == c_LAST_CNT);

  sample_conditioner #(
    .SAMPLE_W (SAMPLE_W),
    .DECIM    (DECIM)
  ) u_cond (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .clear     (w_start_ok),
    .advance   (w_capture && w_pop),
    .word      (bus.left_channel_audio_in),
    .keep      (w_keep),
    .sample    (w_sample),
    .magnitude (w_mag)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start) w_state_nxt = ST_ARM;
      ST_ARM: begin
        if (stop)       w_state_nxt = ST_DONE;
        else if (w_pop) w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: if (stop || w_last) w_state_nxt = ST_DONE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state        <= ST_IDLE;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_mem_wren     <= 1'b0;
      r_mem_address  <= '0;
      r_mem_data     <= '0;
      r_sample_count <= '0;
      r_peak         <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= (w_state_nxt == ST_ARM) || (w_state_nxt == ST_CAPTURE);
      r_done     <= (w_state_nxt == ST_DONE);
      r_mem_wren <= w_kept;
      if (w_start_ok) begin
        r_sample_count <= '0;
        r_peak         <= '0;
      end
      // Write, count and peak all land on the edge after the pop.
      if (w_kept) begin
        r_mem_address  <= r_sample_count[ADDR_W-1:0];
        r_mem_data     <= w_sample;
        r_sample_count <= r_sample_count + c_ONE;
        if (w_mag > r_peak) r_peak <= w_mag;
      end
    end
  end

  assign bus.mem_wren    = r_mem_wren;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_data    = r_mem_data;
  assign busy            = r_busy;
  assign done            = r_done;
  assign sample_count    = r_sample_count;
  assign peak            = r_peak;

endmodule
`default_nettype wire

// File: tb/tb_mic_capture.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : tb_mic_capture                                               |
// | Brief  : Two-configuration bench for mic_capture with reference model |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_mic_capture;

  localparam int SW = 10;

  logic        CLOCK_50 = 1'b0;
  logic        resetn;
  logic        start;
  logic        stop;
  logic        avail;
  logic [31:0] word;

  logic        busy_a, done_a, busy_b, done_b;
  logic [6:0]  cnt_a;
  logic [4:0]  cnt_b;
  logic [8:0]  peak_a, peak_b;

  mic_capture_if #(.ADDR_W(6), .SAMPLE_W(SW)) bus_a ();
  mic_capture_if #(.ADDR_W(4), .SAMPLE_W(SW)) bus_b ();

  assign bus_a.audio_in_available    = avail;
  assign bus_a.left_channel_audio_in = word;
  assign bus_b.audio_in_available    = avail;
  assign bus_b.left_channel_audio_in = word;

  mic_capture #(.DEPTH(64), .ADDR_W(6), .SAMPLE_W(SW), .DECIM(1)) dut_a (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start), .stop(stop),
    .bus(bus_a), .busy(busy_a), .done(done_a),
    .sample_count(cnt_a), .peak(peak_a)
  );

  mic_capture #(.DEPTH(16), .ADDR_W(4), .SAMPLE_W(SW), .DECIM(4)) dut_b (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start), .stop(stop),
    .bus(bus_b), .busy(busy_b), .done(done_b),
    .sample_count(cnt_b), .peak(peak_b)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks;
  int n_errors;
  int wr_a, wr_b;

  // Reference model: index 0 follows dut_a, index 1 follows dut_b.
  int m_busy [2];
  int m_flush[2];
  int m_done [2];
  int m_count[2];
  int m_peak [2];
  int m_pops [2];
  int m_wren [2];
  int m_addr [2];
  int m_data [2];

  typedef struct {
    logic [31:0] word;
    logic [9:0]  data;
    int          mag;
  } vec_t;
  vec_t vecs[7];

  function automatic int decim_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int depth_of(input int i);
    return (i == 0) ? 64 : 16;
  endfunction

  function automatic logic [63:0] pack(input logic w, input logic [11:0] ad,
                                       input logic [9:0] dt, input logic [11:0] ct,
                                       input logic [9:0] pk, input logic b, input logic d);
    return {17'd0, w, ad, dt, ct, pk, b, d};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_flush[i] = 0; m_done[i] = 0; m_count[i] = 0;
      m_peak[i] = 0; m_pops[i] = 0;  m_wren[i] = 0; m_addr[i]  = 0; m_data[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input logic s, input logic p,
                            input logic a, input logic [31:0] w);
    int smp;
    int mag;
    m_wren[i] = 0;
    if (m_busy[i] == 0) begin
      if (s) begin
        m_busy[i] = 1; m_flush[i] = 1; m_done[i] = 0;
        m_count[i] = 0; m_peak[i] = 0; m_pops[i] = 0;
      end
    end else if (m_flush[i] != 0) begin
      if (p) begin
        m_busy[i] = 0; m_done[i] = 1;
      end else if (a) begin
        m_flush[i] = 0;
      end
    end else begin
      if (a) begin
        if (m_pops[i] % decim_of(i) == 0) begin
          smp = $signed(w[31:22]);
          mag = (smp < 0) ? -smp : smp;
          if (mag > 511) mag = 511;
          m_wren[i] = 1;
          m_addr[i] = m_count[i];
          m_data[i] = int'(w[31:22]);
          if (mag > m_peak[i]) m_peak[i] = mag;
          m_count[i]++;
        end
        m_pops[i]++;
      end
      if (p || m_count[i] == depth_of(i)) begin
        m_busy[i] = 0; m_done[i] = 1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, " dut_a"},
          pack(bus_a.mem_wren, 12'(bus_a.mem_address), bus_a.mem_data,
               12'(cnt_a), 10'(peak_a), busy_a, done_a),
          pack(m_wren[0] != 0, 12'(m_addr[0]), 10'(m_data[0]),
               12'(m_count[0]), 10'(m_peak[0]), m_busy[0] != 0, m_done[0] != 0));
    check({tag, " dut_b"},
          pack(bus_b.mem_wren, 12'(bus_b.mem_address), bus_b.mem_data,
               12'(cnt_b), 10'(peak_b), busy_b, done_b),
          pack(m_wren[1] != 0, 12'(m_addr[1]), 10'(m_data[1]),
               12'(m_count[1]), 10'(m_peak[1]), m_busy[1] != 0, m_done[1] != 0));
  endtask

  // One clock: drive at negedge, predict, compare just after the rising edge.
  task automatic cycle(input logic s, input logic p, input logic a, input logic [31:0] w);
    start = s; stop = p; avail = a; word = w;
    #1;
    check("read_audio_in", {62'd0, bus_b.read_audio_in, bus_a.read_audio_in}, {62'd0, a, a});
    model_step(0, s, p, a, w);
    model_step(1, s, p, a, w);
    @(posedge CLOCK_50);
    #1;
    compare_all("cycle");
    if (bus_a.mem_wren === 1'b1) wr_a++;
    if (bus_b.mem_wren === 1'b1) wr_b++;
    @(negedge CLOCK_50);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

  initial begin
    int pk_run;
    vecs[0] = '{32'h0000_0000, 10'h000, 0};
    vecs[1] = '{32'h0040_0000, 10'h001, 1};
    vecs[2] = '{32'h7FC0_0000, 10'h1FF, 511};
    vecs[3] = '{32'hFFC0_0000, 10'h3FF, 1};
    vecs[4] = '{32'h8000_0000, 10'h200, 511};
    vecs[5] = '{32'hFF80_0000, 10'h3FE, 2};
    vecs[6] = '{32'h1234_5678, 10'h048, 72};

    n_checks = 0; n_errors = 0; wr_a = 0; wr_b = 0;
    resetn = 1'b0; start = 1'b0; stop = 1'b0; avail = 1'b0; word = '0;
    model_reset();
    repeat (3) @(negedge CLOCK_50);
    avail = 1'b1; #1;
    check("reset read_audio_in high", 64'(bus_a.read_audio_in), 64'd1);
    avail = 1'b0; #1;
    check("reset read_audio_in low", 64'(bus_a.read_audio_in), 64'd0);
    compare_all("reset");
    resetn = 1'b1;
    @(negedge CLOCK_50);

    // 20 words with available held high; the first is the flush word
    wr_a = 0; wr_b = 0;
    cycle(1, 0, 0, 0);
    for (int k = 0; k < 20; k++) cycle(0, 0, 1, $urandom);
    check("run20 count_a", 64'(cnt_a), 64'd19);
    check("run20 writes_a", 64'(wr_a), 64'd19);
    check("run20 count_b", 64'(cnt_b), 64'd5);
    cycle(0, 1, 0, 0);

    // Run both buffers to full; further pops must not write
    wr_a = 0; wr_b = 0;
    cycle(1, 0, 0, 0);
    for (int k = 0; k < 80; k++) cycle(0, 0, 1, $urandom);
    check("full count_a", 64'(cnt_a), 64'd64);
    check("full writes_a", 64'(wr_a), 64'd64);
    check("full done_a", 64'(done_a), 64'd1);
    check("full count_b", 64'(cnt_b), 64'd16);
    check("full writes_b", 64'(wr_b), 64'd16);
    check("full done_b", 64'(done_b), 64'd1);
    cycle(0, 1, 0, 0);

    // 40 pops in CAPTURE at DECIM=4 give 10 writes
    wr_a = 0; wr_b = 0;
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, $urandom);
    for (int k = 0; k < 40; k++) cycle(0, 0, 1, $urandom);
    check("decim writes_b", 64'(wr_b), 64'd10);
    check("decim count_b", 64'(cnt_b), 64'd10);
    cycle(0, 1, 0, 0);

    // Stop coincident with the kept pop at count 5
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, $urandom);
    for (int k = 0; k < 5; k++) cycle(0, 0, 1, $urandom);
    cycle(0, 1, 1, $urandom);
    check("stop wren_a", 64'(bus_a.mem_wren), 64'd1);
    check("stop addr_a", 64'(bus_a.mem_address), 64'd5);
    check("stop count_a", 64'(cnt_a), 64'd6);
    check("stop done_a", {62'd0, busy_a, done_a}, 64'd1);
    cycle(1, 0, 0, 0);
    check("restart count_a", 64'(cnt_a), 64'd0);
    check("restart busy_a", {62'd0, busy_a, done_a}, 64'd2);
    cycle(1, 1, 0, 0);
    check("arm stop done_a", {62'd0, busy_a, done_a}, 64'd1);
    check("arm stop count_a", 64'(cnt_a), 64'd0);
    cycle(1, 1, 0, 0);
    check("start wins busy_a", {62'd0, busy_a, done_a}, 64'd2);
    cycle(0, 1, 0, 0);

    // Sample extraction and magnitude table
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 32'h0);
    pk_run = 0;
    for (int k = 0; k < 7; k++) begin
      cycle(0, 0, 1, vecs[k].word);
      if (vecs[k].mag > pk_run) pk_run = vecs[k].mag;
      check("table wren", 64'(bus_a.mem_wren), 64'd1);
      check("table data", 64'(bus_a.mem_data), 64'(vecs[k].data));
      check("table peak", 64'(peak_a), 64'(pk_run));
    end
    cycle(0, 1, 0, 0);
    check("table final peak", 64'(peak_a), 64'd511);

    // Asynchronous reset mid-capture at count 7
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, $urandom);
    for (int k = 0; k < 7; k++) cycle(0, 0, 1, $urandom);
    check("prereset wren_a", 64'(bus_a.mem_wren), 64'd1);
    check("prereset count_a", 64'(cnt_a), 64'd7);
    avail = 1'b1;
    #2 resetn = 1'b0;
    #1;
    check("midreset wren_a", 64'(bus_a.mem_wren), 64'd0);
    check("midreset count_a", 64'(cnt_a), 64'd0);
    check("midreset busy_a", {62'd0, busy_a, done_a}, 64'd0);
    check("midreset read high", 64'(bus_a.read_audio_in), 64'd1);
    avail = 1'b0; #1;
    check("midreset read low", 64'(bus_a.read_audio_in), 64'd0);
    model_reset();
    compare_all("midreset");
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    resetn = 1'b1;

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0,
            $urandom_range(0, 3) != 0, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
